// File: rtl/e203_thread_pc_ctx_if.sv
`default_nettype none
// ============================================================================
// Module   : e203_thread_pc_ctx_if
// Purpose  : Fetch-redirect handshake bundle between the thread PC context
//            block (master) and the IFU (slave).
// Signals  : redir_valid  - redirect request (master -> slave)
//            redir_ready  - redirect accepted (slave -> master)
//            redir_pc     - redirect target PC, PC_W bits
//            redir_thread - one-hot thread owning redir_pc
// Revision : 1.0 - initial release
// ============================================================================
interface e203_thread_pc_ctx_if #(
  parameter int unsigned PC_W = 32
) ();
  logic            redir_valid;
  logic            redir_ready;
  logic [PC_W-1:0] redir_pc;
  logic [1:0]      redir_thread;

  modport master (
    output redir_valid,
    output redir_pc,
    output redir_thread,
    input  redir_ready
  );

  modport slave (
    input  redir_valid,
    input  redir_pc,
    input  redir_thread,
    output redir_ready
  );
endinterface
`default_nettype wire

// File: rtl/e203_thread_pc_ctx.sv
`default_nettype none
// ============================================================================
// Module   : e203_thread_pc_ctx
// Purpose  : Two-thread PC context store. On an accepted context switch the
//            outgoing thread's resume PC is saved and a fetch redirect to the
//            incoming thread's saved PC is issued to the IFU, held until the
//            IFU accepts it.
// Ports    : clk, rst_n (async, active-low)
//            i_switch_en       - one-cycle switch request
//            i_thread_sel      - one-hot outgoing thread
//            i_thread_sel_next - one-hot incoming thread
//            i_cur_pc          - resume PC of outgoing thread
//            redir_if          - redirect handshake (master modport)
//            o_ifetch_wait     - high while a redirect is pending
//            o_sw_cnt0/1       - per-thread switch-in counters (stats only)
// Config   : define E203_THREAD_CTX_STATS_EN to build the saturating
//            switch-in counters and their output ports.
// Revision : 1.0 - initial release
// ============================================================================
module e203_thread_pc_ctx #(
  parameter int unsigned     PC_W   = 32,
  parameter logic [PC_W-1:0] RST_PC = PC_W'(32'h8000_0000),
  parameter int unsigned     CNT_W  = 16
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            i_switch_en,
  input  wire logic [1:0]      i_thread_sel,
  input  wire logic [1:0]      i_thread_sel_next,
  input  wire logic [PC_W-1:0] i_cur_pc,
  e203_thread_pc_ctx_if.master redir_if,
  output logic                 o_ifetch_wait
`ifdef E203_THREAD_CTX_STATS_EN
  ,
  output logic [CNT_W-1:0]     o_sw_cnt0,
  output logic [CNT_W-1:0]     o_sw_cnt1
`endif
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_REDIR = 1'b1
  } state_t;

  state_t          r_state;
  logic [PC_W-1:0] r_slot0;
  logic [PC_W-1:0] r_slot1;
  logic [PC_W-1:0] r_redir_pc;
  logic [1:0]      r_redir_thread;

  logic            w_sel_onehot;
  logic            w_next_onehot;
  logic            w_accept;
  logic [PC_W-1:0] w_incoming_pc;

  // For a 2-bit vector, odd parity means exactly one bit set.
  assign w_sel_onehot  = ^i_thread_sel;
  assign w_next_onehot = ^i_thread_sel_next;
  assign w_accept      = (r_state == ST_IDLE) && i_switch_en &&
                         w_sel_onehot && w_next_onehot &&
                         (i_thread_sel != i_thread_sel_next);

  assign w_incoming_pc = i_thread_sel_next[1] ? r_slot1 : r_slot0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_slot0        <= RST_PC;
      r_slot1        <= RST_PC;
      r_redir_pc     <= RST_PC;
      r_redir_thread <= 2'b01;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (i_thread_sel[0]) r_slot0 <= i_cur_pc;
            else                 r_slot1 <= i_cur_pc;
            // Slot read uses the pre-edge value, so a same-edge save to the
            // outgoing slot never aliases the incoming target.
            r_redir_pc     <= w_incoming_pc;
            r_redir_thread <= i_thread_sel_next;
            r_state        <= ST_REDIR;
          end
        end
        ST_REDIR: begin
          // Target is frozen here; switch requests are ignored until the IFU
          // takes the redirect.
          if (redir_if.redir_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Pending flag is decoded purely from the state register, keeping
  // i_switch_en off any combinational path to the outputs.
  assign redir_if.redir_valid  = (r_state == ST_REDIR);
  assign redir_if.redir_pc     = r_redir_pc;
  assign redir_if.redir_thread = r_redir_thread;
  assign o_ifetch_wait         = (r_state == ST_REDIR);

`ifdef E203_THREAD_CTX_STATS_EN
  logic [CNT_W-1:0] r_sw_cnt0;
  logic [CNT_W-1:0] r_sw_cnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_cnt0 <= '0;
      r_sw_cnt1 <= '0;
    end else if (w_accept) begin
      if (i_thread_sel_next[0] && (r_sw_cnt0 != {CNT_W{1'b1}}))
        r_sw_cnt0 <= r_sw_cnt0 + 1'b1;
      if (i_thread_sel_next[1] && (r_sw_cnt1 != {CNT_W{1'b1}}))
        r_sw_cnt1 <= r_sw_cnt1 + 1'b1;
    end
  end

  assign o_sw_cnt0 = r_sw_cnt0;
  assign o_sw_cnt1 = r_sw_cnt1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_e203_thread_pc_ctx.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_thread_pc_ctx
// Purpose  : Directed self-checking bench for e203_thread_pc_ctx. Counter
//            checks are compiled in when E203_THREAD_CTX_STATS_EN is defined
//            (counters built 4 bits wide so saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_e203_thread_pc_ctx;

  localparam int unsigned PC_W  = 32;
  localparam int unsigned CNT_W = 4;

  logic            clk;
  logic            rst_n;
  logic            switch_en;
  logic [1:0]      thread_sel;
  logic [1:0]      thread_sel_next;
  logic [PC_W-1:0] cur_pc;
  logic            ifetch_wait;
`ifdef E203_THREAD_CTX_STATS_EN
  logic [CNT_W-1:0] sw_cnt0;
  logic [CNT_W-1:0] sw_cnt1;
`endif

  int checks;
  int errors;

  e203_thread_pc_ctx_if #(.PC_W(PC_W)) rif ();

  e203_thread_pc_ctx #(
    .PC_W  (PC_W),
    .RST_PC(32'h8000_0000),
    .CNT_W (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_switch_en      (switch_en),
    .i_thread_sel     (thread_sel),
    .i_thread_sel_next(thread_sel_next),
    .i_cur_pc         (cur_pc),
    .redir_if         (rif),
    .o_ifetch_wait    (ifetch_wait)
`ifdef E203_THREAD_CTX_STATS_EN
    ,
    .o_sw_cnt0        (sw_cnt0),
    .o_sw_cnt1        (sw_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Redirect output bundle check.
  task automatic chk_redir(input string tag, input logic v, input logic [31:0] pc,
                           input logic [1:0] th);
    chk({tag, "_valid"}, 64'(rif.redir_valid), 64'(v));
    chk({tag, "_wait"},  64'(ifetch_wait),     64'(v));
    chk({tag, "_pc"},    64'(rif.redir_pc),    64'(pc));
    chk({tag, "_thr"},   64'(rif.redir_thread),64'(th));
  endtask

  // One-cycle switch pulse; returns #1 after the sampling edge.
  task automatic pulse_switch(input logic [1:0] sel, input logic [1:0] nxt,
                              input logic [31:0] pc);
    switch_en       = 1'b1;
    thread_sel      = sel;
    thread_sel_next = nxt;
    cur_pc          = pc;
    @(posedge clk); #1;
    switch_en       = 1'b0;
  endtask

  task automatic handshake();
    rif.redir_ready = 1'b1;
    @(posedge clk); #1;
    rif.redir_ready = 1'b0;
  endtask

  logic [31:0] m_slot0;
  logic [31:0] m_slot1;
  int          exp_c0;
  int          exp_c1;

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    switch_en       = 1'b0;
    thread_sel      = 2'b01;
    thread_sel_next = 2'b10;
    cur_pc          = '0;
    rif.redir_ready = 1'b0;

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk_redir("rst", 1'b0, 32'h8000_0000, 2'b01);
`ifdef E203_THREAD_CTX_STATS_EN
    chk("rst_cnt0", 64'(sw_cnt0), 64'd0);
    chk("rst_cnt1", 64'(sw_cnt1), 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_redir("idle0", 1'b0, 32'h8000_0000, 2'b01);

    // ---- first switch 0 -> 1
    pulse_switch(2'b01, 2'b10, 32'h8000_0100);
    chk_redir("sw1", 1'b1, 32'h8000_0000, 2'b10);

    // ---- ready low for 3 cycles, with an ignored switch in the middle
    @(posedge clk); #1;
    chk_redir("hold1", 1'b1, 32'h8000_0000, 2'b10);
    pulse_switch(2'b10, 2'b01, 32'hDEAD_BEEF);
    chk_redir("hold2", 1'b1, 32'h8000_0000, 2'b10);
    @(posedge clk); #1;
    chk_redir("hold3", 1'b1, 32'h8000_0000, 2'b10);
    handshake();
    chk("hs1_valid", 64'(rif.redir_valid), 64'd0);
    chk("hs1_wait",  64'(ifetch_wait),     64'd0);
`ifdef E203_THREAD_CTX_STATS_EN
    chk("ign_cnt0", 64'(sw_cnt0), 64'd0);
    chk("ign_cnt1", 64'(sw_cnt1), 64'd1);
`endif

    // ---- switch back 1 -> 0
    pulse_switch(2'b10, 2'b01, 32'h8000_0200);
    chk_redir("sw2", 1'b1, 32'h8000_0100, 2'b01);
    handshake();
    chk("hs2_valid", 64'(rif.redir_valid), 64'd0);

    // ---- back-to-back: switch right after immediate handshake
    pulse_switch(2'b01, 2'b10, 32'h8000_0300);
    chk_redir("sw3", 1'b1, 32'h8000_0200, 2'b10);
    handshake();

    // ---- invalid selects and ready while idle
    pulse_switch(2'b01, 2'b01, 32'h1111_1111);
    chk_redir("bad_same", 1'b0, 32'h8000_0200, 2'b10);
    pulse_switch(2'b11, 2'b10, 32'h2222_2222);
    chk_redir("bad_sel", 1'b0, 32'h8000_0200, 2'b10);
    pulse_switch(2'b10, 2'b11, 32'h3333_3333);
    chk_redir("bad_next", 1'b0, 32'h8000_0200, 2'b10);
    handshake();
    chk_redir("rdy_idle", 1'b0, 32'h8000_0200, 2'b10);

    // slot0 must still hold 0x8000_0300
    pulse_switch(2'b10, 2'b01, 32'h8000_0400);
    chk_redir("sw4", 1'b1, 32'h8000_0300, 2'b01);

    // ---- asynchronous reset while a redirect is pending
    #3;
    rst_n = 1'b0;
    #1;
    chk_redir("arst", 1'b0, 32'h8000_0000, 2'b01);
`ifdef E203_THREAD_CTX_STATS_EN
    chk("arst_cnt0", 64'(sw_cnt0), 64'd0);
    chk("arst_cnt1", 64'(sw_cnt1), 64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_redir("post_rst", 1'b0, 32'h8000_0000, 2'b01);

    pulse_switch(2'b01, 2'b10, 32'h8000_0500);
    chk_redir("sw5", 1'b1, 32'h8000_0000, 2'b10);
    handshake();
    m_slot0 = 32'h8000_0500;
    m_slot1 = 32'h8000_0000;
    exp_c0  = 0;
    exp_c1  = 1;

    // ---- alternate switches: 20 total into thread 1, 19 into thread 0
    for (int i = 0; i < 19; i++) begin
      pulse_switch(2'b10, 2'b01, 32'h9000_0000 + 32'(i));
      chk_redir("loop_to0", 1'b1, m_slot0, 2'b01);
      m_slot1 = 32'h9000_0000 + 32'(i);
      exp_c0  = (exp_c0 < 15) ? exp_c0 + 1 : 15;
      handshake();
      pulse_switch(2'b01, 2'b10, 32'hA000_0000 + 32'(i));
      chk_redir("loop_to1", 1'b1, m_slot1, 2'b10);
      m_slot0 = 32'hA000_0000 + 32'(i);
      exp_c1  = (exp_c1 < 15) ? exp_c1 + 1 : 15;
      handshake();
`ifdef E203_THREAD_CTX_STATS_EN
      chk("loop_cnt0", 64'(sw_cnt0), 64'(exp_c0));
      chk("loop_cnt1", 64'(sw_cnt1), 64'(exp_c1));
`endif
    end
`ifdef E203_THREAD_CTX_STATS_EN
    chk("sat_cnt1", 64'(sw_cnt1), 64'd15);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/e203_thread_pc_ctx.md
E203_THREAD_PC_CTX -- requirements
Module: e203_thread_pc_ctx

Interface
REQ-001 Parameter PC_W, default 32, width of all PC values.
REQ-002 Parameter RST_PC, default 32'h8000_0000, initial resume PC of both thread slots.
REQ-003 Parameter CNT_W, default 16, width of per-thread switch counters (stats feature only).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 switch_en  input  1  one-cycle switch request from context-switch control.
REQ-007 thread_sel  input  2  one-hot current (outgoing) thread.
REQ-008 thread_sel_next  input  2  one-hot incoming thread.
REQ-009 cur_pc  input  PC_W  resume PC of outgoing thread, valid while switch_en=1.
REQ-010 redir_valid  output  1  fetch-redirect request to IFU.
REQ-011 redir_ready  input  1  IFU accepts redirect.
REQ-012 redir_pc  output  PC_W  redirect target PC.
REQ-013 redir_thread  output  2  one-hot thread owning redir_pc.
REQ-014 ifetch_wait  output  1  high while a redirect is pending; fed back to block switching.
REQ-015 sw_cnt0, sw_cnt1  output  CNT_W each  switch-in counts for thread 0/1 (stats feature only).

Function
REQ-016 Two PC slots, slot[i] for thread i, each PC_W bits.
REQ-017 FSM states: IDLE, REDIR.
REQ-018 Switch accepted only in IDLE with switch_en=1, thread_sel and thread_sel_next each exactly one-hot and different; otherwise switch_en ignored, no state change.
REQ-019 On accepted switch: slot[outgoing] <= cur_pc; redir_pc <= slot[incoming] (value before this edge); redir_thread <= thread_sel_next; state -> REDIR.
REQ-020 redir_valid = (state==REDIR); asserted exactly one cycle after the accepting switch_en edge.
REQ-021 In REDIR, redir_pc and redir_thread held stable until handshake (redir_valid & redir_ready).
REQ-022 Handshake in REDIR: state -> IDLE next edge; redir_valid low the following cycle.
REQ-023 redir_ready=1 while IDLE has no effect.
REQ-024 ifetch_wait = (state==REDIR), combinational from state register; no combinational path from switch_en.
REQ-025 switch_en=1 in REDIR is ignored; slots, redir_pc, counters unchanged.
REQ-026 Minimum switch-to-switch spacing: 2 cycles (switch, REDIR with immediate ready, then IDLE).

Reset
REQ-027 On rst_n low: state=IDLE, redir_valid=0, ifetch_wait=0, redir_pc=RST_PC, redir_thread=2'b01, slot[0]=slot[1]=RST_PC, sw_cnt0=sw_cnt1=0.
REQ-028 Reset mid-REDIR aborts the pending redirect; no handshake completes; outputs reach reset values asynchronously.

Configuration
REQ-029 Macro E203_THREAD_CTX_STATS_EN: when defined, sw_cnt0/sw_cnt1 exist; counter of incoming thread increments by 1 on each accepted switch, saturating at all-ones.
REQ-030 Without E203_THREAD_CTX_STATS_EN: sw_cnt0/sw_cnt1 ports and counter logic absent; all other behaviour identical.

Verification
REQ-031 Reset, switch_en with thread_sel=01, next=10, cur_pc=0x8000_0100 -> next cycle redir_valid=1, redir_pc=0x8000_0000, redir_thread=10, ifetch_wait=1; slot[0]=0x8000_0100.
REQ-032 Then redir_ready low 3 cycles then high -> redir_pc/thread stable 4 cycles, redir_valid drops after handshake edge; switch back with cur_pc=0x8000_0200 -> redir_pc=0x8000_0100.
REQ-033 switch_en pulsed during REDIR with cur_pc=0xDEAD_BEEF -> ignored; subsequent redirect targets unchanged, no counter increment.
REQ-034 switch_en with thread_sel=thread_sel_next=01, or non-one-hot 11 -> no redirect, slots unchanged.
REQ-035 Assert rst_n low while redir_valid=1 -> outputs immediately at reset values; after release first switch to thread 1 redirects to 0x8000_0000.
REQ-036 With E203_THREAD_CTX_STATS_EN and CNT_W=4: 20 switches into thread 1 -> sw_cnt1 saturates at 15; sw_cnt0 counts switches into thread 0 only.
